spi_slave_responder: RTL

- SPI target-side transceiver clocked by the system clk. It is the responder that pairs with the team's 12-bit SPI master/receiver pair.
- It oversamples the master's sclk/cs/mosi through synchronizers and captures a DATA_W-bit word from MOSI.
- In the same frame it shifts a locally supplied response word out on MISO, MSB first.
- A one-entry TX holding buffer with a valid/ready handshake feeds the response. A single-cycle rx_valid pulse returns the received word to the local logic.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_slave_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and responder state encoding
package spi_pkg;
  localparam int SPI_DATA_W = 12;
  localparam int SPI_SYNC_STAGES = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} spi_rsp_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer with registered-history edge pulses
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI target, captures MOSI words and shifts a buffered response on MISO
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              cs_in,
  input  logic              mosi_in,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  logic sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s;
  spi_rsp_state_e state;
  logic buf_full;
  logic [DATA_W-1:0] buf_data, txsr, rxsr;
  logic [CW-1:0] bitcnt;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .reset(reset), .d(sclk_in), .q(), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .reset(reset), .d(cs_in), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .reset(reset), .d(mosi_in), .q(mosi_s), .rise(), .fall());
  assign tx_ready = ~buf_full;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      txsr <= '0;
      rxsr <= '0;
      bitcnt <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err <= 1'b0;
      // an empty buffer loads even on the frame-start cycle; that frame still underruns
      if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end
      case (state)
        IDLE: begin
          miso <= 1'b0;
          miso_oe <= 1'b0;
          if (cs_rise) begin
            txsr <= buf_full ? buf_data : IDLE_WORD;
            miso <= buf_full ? buf_data[DATA_W-1] : IDLE_WORD[DATA_W-1];
            miso_oe <= 1'b1;
            tx_underrun <= ~buf_full;
            if (buf_full) buf_full <= 1'b0;
            bitcnt <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rxsr <= {rxsr[DATA_W-2:0], mosi_s};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST) begin
              rx_data <= {rxsr[DATA_W-2:0], mosi_s};
              rx_valid <= 1'b1;
              miso <= 1'b0;
              state <= HOLD;
            end
          end else if (cs_fall) begin
            frame_err <= 1'b1;
            miso <= 1'b0;
            miso_oe <= 1'b0;
            state <= IDLE;
          end else if (sclk_fall && bitcnt < FULL) begin
            txsr <= txsr << 1;
            miso <= txsr[DATA_W-2];
          end
        end
        HOLD: begin
          miso <= 1'b0;
          // level check also covers a cs_fall that coincided with the final sclk_rise
          if (!cs_s) begin
            miso_oe <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
